fwd_ctrl: RTL and testbench
===========================

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter: AW, default 5, register-address width.
REQ-002 Parameter: CW, default 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  ID-stage instruction present.
REQ-006 id_rs, id_rt  in  AW each  ID source register addresses.
REQ-007 id_rd  in  AW  ID destination register address.
REQ-008 id_reg_write  in  1  ID instruction writes id_rd.
REQ-009 id_mem_read  in  1  ID instruction is a load.
REQ-010 id_use_imm  in  1  ID operand B is the immediate.
REQ-011 hold  in  1  global pipeline freeze, e.g. memory wait.
REQ-012 stall  out  1  combinational load-use stall: hold PC and IF/ID, insert bubble.
REQ-013 ex_sel_a, ex_sel_b  out  2 each  registered selects for the EX-stage 4:1 operand muxes.
REQ-014 stall_cnt  out  CW  saturating count of load-use stall cycles.

Function
REQ-015 Select encoding SHALL be:
- 00 register-file value
- 01 EX/MEM result
- 10 MEM/WB result
- 11 immediate (B only; ex_sel_a never 11)
REQ-016 Two internal in-flight records SHALL be kept, EXR then MEMR, each {valid, wr, load, rd}.
REQ-017 Advance SHALL occur when hold=0 and stall=0:
- MEMR <= EXR
- EXR <= {id_valid, id_reg_write, id_mem_read, id_rd}
- ex_sel_a/ex_sel_b <= values computed from ID inputs
REQ-018 When stall=1 and hold=0:
- MEMR <= EXR
- EXR <= bubble (all zero)
- ex_sel_a/ex_sel_b <= 00
REQ-019 When hold=1, EXR, MEMR, selects and stall_cnt SHALL hold, regardless of stall.
REQ-020 Per source s (rs for A, rt for B), with match(R) = R.valid and R.wr and R.rd==s and s!=0:
- if match(EXR), select 01
- else if match(MEMR), select 10
- else 00
REQ-021 EXR SHALL take priority over MEMR when both match.
REQ-022 If id_use_imm=1, ex_sel_b SHALL be 11 regardless of rt matches.
REQ-023 A register address of 0 SHALL never forward.
REQ-024 stall = id_valid and EXR.valid and EXR.wr and EXR.load and EXR.rd!=0 and EXR.rd in {id_rs, id_rt used}.
REQ-025 rt counts as used only when id_use_imm=0.
REQ-026 A load-use stall SHALL last exactly one advancing cycle; after the bubble the load sits in MEMR and forwards via 10.
REQ-027 id_valid=0 SHALL never assert stall and SHALL load a bubble into EXR on advance.
REQ-028 stall_cnt SHALL increment on each clock where stall=1 and hold=0, and saturate at all-ones.
REQ-029 No output SHALL have more than one cycle latency; stall SHALL be purely combinational from inputs and EXR.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear:
- EXR and MEMR valid bits
- ex_sel_a = ex_sel_b = 00
- stall_cnt = 0
REQ-031 stall SHALL read 0 during reset, since EXR is invalid.
REQ-032 Reset asserted mid-stall or mid-hold SHALL discard all in-flight records; the first post-reset instruction sees no forwarding.

Structure
REQ-033 A shared package SHALL hold:
- select encoding constants SEL_RF, SEL_EXM, SEL_MWB, SEL_IMM
- the in-flight record typedef
REQ-034 One sub-module, fwd_match, SHALL compute the select for one source; it is instantiated for A and B.
REQ-035 Hazard, record and counter logic SHALL reside in fwd_ctrl.

Verification
REQ-036 Back-to-back dependency:
- stimulus: add rd=5 then sub rs=5, rt=6
- response: ex_sel_a=01 and ex_sel_b=00 in the cycle sub is in EX
REQ-037 Distance-2 dependency plus priority:
- stimulus: rd=5, independent, then rs=5 -> response: ex_sel_a=10
- stimulus: rd=5, rd=5, then rs=5 -> response: ex_sel_a=01
REQ-038 Load-use:
- stimulus: lw rd=7 then add rt=7
- response: stall=1 for one cycle, stall_cnt=1, bubble selects 00, then ex_sel_b=10
- stimulus: same pair with id_use_imm=1 and rs!=7 -> response: no stall, ex_sel_b=11
REQ-039 Register zero: stimulus: writer rd=0 then reader rs=0 -> response: ex_sel_a=00 and no stall, even for a load.
REQ-040 Hold and reset:
- stimulus: assert hold for 3 cycles during a pending load-use -> response: stall visible, state and stall_cnt unchanged
- stimulus: rst_n low mid-sequence -> response: all outputs 0 immediately
- stimulus: stall_cnt at all-ones plus one more stall -> response: stall_cnt stays at all-ones

Source files
------------

// File: rtl/fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller:
// operand-select encodings and the in-flight instruction record.
package fwd_ctrl_pkg;

  // Record address field is sized for the widest supported AW; narrower
  // addresses are zero-extended on entry.
  localparam int REC_AW = 8;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [REC_AW-1:0] rd;
  } rec_t;

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-stage request / EX-stage select bundle between the decode stage and fwd_ctrl.
interface fwd_ctrl_if #(
  parameter int AW = 5,
  parameter int CW = 16
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_use_imm;
  logic          hold;
  logic          stall;
  logic [1:0]    ex_sel_a;
  logic [1:0]    ex_sel_b;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_use_imm, hold,
    input  stall, ex_sel_a, ex_sel_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_use_imm, hold,
    output stall, ex_sel_a, ex_sel_b, stall_cnt
  );
endinterface

// File: rtl/fwd_ctrl_match.sv
// Operand-select for one ID source register against the EX and MEM in-flight records.
module fwd_match
  import fwd_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  rec_t          exr,
  input  rec_t          memr,
  input  logic          use_imm,
  output logic [1:0]    sel
);

  function automatic logic hit(input rec_t r, input logic [AW-1:0] s);
    return r.valid && r.wr && (s != '0) && (r.rd == REC_AW'(s));
  endfunction

  // Younger producer (EX) wins over older (MEM).
  always_comb begin
    sel = SEL_RF;
    if (use_imm)             sel = SEL_IMM;
    else if (hit(exr, src))  sel = SEL_EXM;
    else if (hit(memr, src)) sel = SEL_MWB;
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control: tracks the EX/MEM in-flight records,
// registers the EX operand selects and counts load-use stall cycles.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input logic     clk,
  input logic     rst_n,
  fwd_ctrl_if.slave bus
);

  rec_t          exr_p1;
  rec_t          memr_p2;
  rec_t          id_rec_p0;
  logic [1:0]    sel_a_p0;
  logic [1:0]    sel_b_p0;
  logic [1:0]    sel_a_p1;
  logic [1:0]    sel_b_p1;
  logic [CW-1:0] stall_cnt_q;
  logic          stall_c;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  always_comb begin
    id_rec_p0       = '0;
    id_rec_p0.valid = bus.id_valid;
    id_rec_p0.wr    = bus.id_reg_write;
    id_rec_p0.load  = bus.id_mem_read;
    id_rec_p0.rd    = REC_AW'(bus.id_rd);
  end

  // rt only participates in the hazard when operand B really reads the register file.
  always_comb begin
    stall_c = 1'b0;
    if (bus.id_valid && exr_p1.valid && exr_p1.wr && exr_p1.load && (exr_p1.rd != '0))
      stall_c = (exr_p1.rd == REC_AW'(bus.id_rs)) ||
                (!bus.id_use_imm && (exr_p1.rd == REC_AW'(bus.id_rt)));
  end

  fwd_match #(.AW(AW)) u_match_a (
    .src     (bus.id_rs),
    .exr     (exr_p1),
    .memr    (memr_p2),
    .use_imm (1'b0),
    .sel     (sel_a_p0)
  );

  fwd_match #(.AW(AW)) u_match_b (
    .src     (bus.id_rt),
    .exr     (exr_p1),
    .memr    (memr_p2),
    .use_imm (bus.id_use_imm),
    .sel     (sel_b_p0)
  );

  // ID -> EX boundary: records advance, selects register; hold freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exr_p1      <= '0;
      memr_p2     <= '0;
      sel_a_p1    <= SEL_RF;
      sel_b_p1    <= SEL_RF;
      stall_cnt_q <= '0;
    end else if (!bus.hold) begin
      memr_p2 <= exr_p1;
      if (stall_c) begin
        exr_p1      <= '0;
        sel_a_p1    <= SEL_RF;
        sel_b_p1    <= SEL_RF;
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end else begin
        exr_p1   <= id_rec_p0;
        sel_a_p1 <= sel_a_p0;
        sel_b_p1 <= sel_b_p0;
      end
    end
  end

  assign bus.stall     = stall_c;
  assign bus.ex_sel_a  = sel_a_p1;
  assign bus.ex_sel_b  = sel_b_p1;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed and randomized bench for fwd_ctrl against a queue-based pipeline model.
module tb_fwd_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    bit valid;
    bit wr;
    bit load;
    int rd;
  } slot_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   e_cnt;
  logic [1:0] e_a;
  logic [1:0] e_b;
  slot_t pipe[$];   // issued slots, youngest first

  fwd_ctrl_if #(.AW(AW), .CW(CW)) bus ();

  fwd_ctrl #(.AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest of the last two issued instructions that writes s supplies the operand.
  function automatic logic [1:0] m_fwd(input int s, input bit imm);
    if (imm) return 2'd3;
    if (s == 0) return 2'd0;
    for (int age = 0; age < 2 && age < pipe.size(); age++)
      if (pipe[age].valid && pipe[age].wr && pipe[age].rd == s)
        return (age == 0) ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_stall(input bit v, input int rs, input int rt, input bit imm);
    if (!v || pipe.size() == 0) return 1'b0;
    if (!(pipe[0].valid && pipe[0].wr && pipe[0].load) || pipe[0].rd == 0) return 1'b0;
    return (pipe[0].rd == rs) || (!imm && pipe[0].rd == rt);
  endfunction

  task automatic step(input bit v, input int rs, input int rt, input int rd,
                      input bit wr, input bit mr, input bit imm, input bit h);
    bit es;
    slot_t s;
    logic [1:0] na, nb;
    bus.id_valid     = v;
    bus.id_rs        = AW'(rs);
    bus.id_rt        = AW'(rt);
    bus.id_rd        = AW'(rd);
    bus.id_reg_write = wr;
    bus.id_mem_read  = mr;
    bus.id_use_imm   = imm;
    bus.hold         = h;
    #1;
    es = m_stall(v, rs, rt, imm);
    chk("stall", {31'd0, bus.stall}, {31'd0, es});
    na = m_fwd(rs, 1'b0);
    nb = m_fwd(rt, imm);
    @(posedge clk);
    if (!h) begin
      if (es) begin
        s = '{valid: 1'b0, wr: 1'b0, load: 1'b0, rd: 0};
        e_a = 2'd0;
        e_b = 2'd0;
        if (e_cnt < CNT_MAX) e_cnt++;
      end else begin
        s = '{valid: v, wr: wr, load: mr, rd: rd};
        e_a = na;
        e_b = nb;
      end
      pipe.push_front(s);
      if (pipe.size() > 2) void'(pipe.pop_back());
    end
    #1;
    chk("ex_sel_a", {30'd0, bus.ex_sel_a}, {30'd0, e_a});
    chk("ex_sel_b", {30'd0, bus.ex_sel_b}, {30'd0, e_b});
    chk("stall_cnt", {28'd0, bus.stall_cnt}, 32'(e_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pipe.delete();
    e_a = 2'd0;
    e_b = 2'd0;
    e_cnt = 0;
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_sel_a", {30'd0, bus.ex_sel_a}, 32'd0);
    chk("rst_sel_b", {30'd0, bus.ex_sel_b}, 32'd0);
    chk("rst_cnt", {28'd0, bus.stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    e_cnt = 0;
    e_a = 2'd0;
    e_b = 2'd0;
    bus.id_valid = 1'b0;
    bus.id_rs = '0;
    bus.id_rt = '0;
    bus.id_rd = '0;
    bus.id_reg_write = 1'b0;
    bus.id_mem_read = 1'b0;
    bus.id_use_imm = 1'b0;
    bus.hold = 1'b0;
    do_reset();

    // Back-to-back: add r5 ; sub r?, r5, r6
    step(1, 1, 2, 5, 1, 0, 0, 0);
    step(1, 5, 6, 8, 1, 0, 0, 0);
    chk("b2b_sel_a", {30'd0, bus.ex_sel_a}, 32'd1);
    chk("b2b_sel_b", {30'd0, bus.ex_sel_b}, 32'd0);

    // Distance 2, then EX priority over MEM
    step(1, 1, 2, 5, 1, 0, 0, 0);
    step(1, 1, 2, 9, 1, 0, 0, 0);
    step(1, 5, 2, 10, 1, 0, 0, 0);
    chk("dist2_sel_a", {30'd0, bus.ex_sel_a}, 32'd2);
    step(1, 1, 2, 5, 1, 0, 0, 0);
    step(1, 1, 2, 5, 1, 0, 0, 0);
    step(1, 5, 2, 10, 1, 0, 0, 0);
    chk("prio_sel_a", {30'd0, bus.ex_sel_a}, 32'd1);

    // Load-use: lw r7 ; add rt=r7 stalls once, then forwards from MEM/WB
    step(1, 1, 2, 7, 1, 1, 0, 0);
    step(1, 3, 7, 11, 1, 0, 0, 0);
    chk("lu_bubble_b", {30'd0, bus.ex_sel_b}, 32'd0);
    chk("lu_cnt", {28'd0, bus.stall_cnt}, 32'd1);
    step(1, 3, 7, 11, 1, 0, 0, 0);
    chk("lu_fwd_b", {30'd0, bus.ex_sel_b}, 32'd2);
    // Same pair with an immediate operand B: no hazard
    step(1, 1, 2, 7, 1, 1, 0, 0);
    step(1, 3, 7, 11, 1, 0, 1, 0);
    chk("imm_sel_b", {30'd0, bus.ex_sel_b}, 32'd3);
    chk("imm_cnt", {28'd0, bus.stall_cnt}, 32'd1);

    // Register zero never forwards or stalls, even after a load
    step(1, 1, 2, 0, 1, 1, 0, 0);
    step(1, 0, 0, 12, 1, 0, 0, 0);
    chk("r0_sel_a", {30'd0, bus.ex_sel_a}, 32'd0);

    // Hold for 3 cycles during a pending load-use
    step(1, 1, 2, 7, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 7, 4, 13, 1, 0, 0, 1);
    chk("hold_cnt", {28'd0, bus.stall_cnt}, 32'd1);
    step(1, 7, 4, 13, 1, 0, 0, 0);
    step(1, 7, 4, 13, 1, 0, 0, 0);
    chk("hold_fwd_a", {30'd0, bus.ex_sel_a}, 32'd2);

    // Reset in the middle of a pending stall discards the load
    step(1, 1, 2, 6, 1, 1, 0, 0);
    bus.id_rs = AW'(6);
    do_reset();
    step(1, 6, 6, 3, 1, 0, 0, 0);
    chk("post_rst_a", {30'd0, bus.ex_sel_a}, 32'd0);

    // Counter saturation
    for (int i = 0; i <= CNT_MAX; i++) begin
      step(1, 1, 2, 7, 1, 1, 0, 0);
      step(1, 7, 2, 9, 1, 0, 0, 0);
      step(1, 7, 2, 9, 1, 0, 0, 0);
    end
    chk("sat_cnt", {28'd0, bus.stall_cnt}, 32'(CNT_MAX));

    // Randomized traffic over a tiny register space to force hazards
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
